// File: rtl/arp_rx_parser.sv
// arp_rx_parser
// Receive-side front end of the ARP core. It takes raw Ethernet frames from
// an 8-bit AXI-Stream and checks the Ethernet and ARP headers. Each good
// frame produces one parsed record on a valid/ready output.
// The parser never back-pressures the MAC. A frame that cannot be delivered
// (bad header, runt, errored or output still occupied) is dropped and counted.
module arp_rx_parser #(
  parameter int CNT_WIDTH          = 16,
  parameter bit ACCEPT_UNICAST_ANY = 1'b0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [47:0]          local_mac,
  input  logic [31:0]          local_ip,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 m_arp_valid,
  input  logic                 m_arp_ready,
  output logic [15:0]          m_arp_oper,
  output logic [47:0]          m_arp_sha,
  output logic [31:0]          m_arp_spa,
  output logic [47:0]          m_arp_tha,
  output logic [31:0]          m_arp_tpa,
  output logic                 m_arp_tpa_match,
  output logic [CNT_WIDTH-1:0] stat_frames,
  output logic [CNT_WIDTH-1:0] stat_arp_ok,
  output logic [CNT_WIDTH-1:0] stat_drop
);

  // Byte positions inside the frame (big-endian header layout)
  localparam logic [5:0] IDX_DST_LAST = 6'd5;
  localparam logic [5:0] IDX_TPA_LAST = 6'd41;
  localparam logic [5:0] IDX_MAX      = 6'd42;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    RECV      = 1'b0,
    WAIT_LAST = 1'b1
  } parserState_t;

  parserState_t r_state;
  parserState_t w_nextState;

  logic        r_tready;
  logic [5:0]  r_byteIdx;
  logic        r_bad;
  logic        r_dstBcast;
  logic        r_dstLocal;

  // Shadow copy of the ARP fields of the frame currently being parsed
  logic [15:0] r_shOper;
  logic [47:0] r_shSha;
  logic [31:0] r_shSpa;
  logic [47:0] r_shTha;
  logic [31:0] r_shTpa;

  // Output record register
  logic        r_arpValid;
  logic [15:0] r_arpOper;
  logic [47:0] r_arpSha;
  logic [31:0] r_arpSpa;
  logic [47:0] r_arpTha;
  logic [31:0] r_arpTpa;
  logic        r_arpTpaMatch;

  logic [CNT_WIDTH-1:0] r_statFrames;
  logic [CNT_WIDTH-1:0] r_statArpOk;
  logic [CNT_WIDTH-1:0] r_statDrop;

  logic        w_xfer;
  logic        w_lastXfer;
  logic [7:0]  w_localByte;
  logic        w_bcastNext;
  logic        w_localNext;
  logic        w_byteBad;
  logic        w_badNext;
  logic        w_inRecv;
  logic        w_tpaByte;
  logic [31:0] w_tpaNext;
  logic        w_runt;
  logic        w_slotFree;
  logic        w_deliver;
  logic        w_drop;

  assign w_xfer     = s_axis_tvalid && r_tready;
  assign w_lastXfer = w_xfer && s_axis_tlast;
  assign w_inRecv   = (r_state == RECV);

  // The TPA is the last header field; when the frame ends on its final byte
  // the decide logic must see that byte, so the shifted value is formed here
  assign w_tpaByte = w_inRecv && (r_byteIdx >= 6'd38) && (r_byteIdx <= IDX_TPA_LAST);
  assign w_tpaNext = w_tpaByte ? {r_shTpa[23:0], s_axis_tdata} : r_shTpa;

  // Per-byte header check, including the running destination-MAC comparison
  always_comb begin
    w_localByte = 8'h00;
    w_byteBad   = 1'b0;
    case (r_byteIdx)
      6'd0:    w_localByte = local_mac[47:40];
      6'd1:    w_localByte = local_mac[39:32];
      6'd2:    w_localByte = local_mac[31:24];
      6'd3:    w_localByte = local_mac[23:16];
      6'd4:    w_localByte = local_mac[15:8];
      6'd5:    w_localByte = local_mac[7:0];
      default: w_localByte = 8'h00;
    endcase
    w_bcastNext = r_dstBcast && (s_axis_tdata == 8'hFF);
    w_localNext = r_dstLocal && (s_axis_tdata == w_localByte);
    if (w_inRecv) begin
      case (r_byteIdx)
        IDX_DST_LAST: w_byteBad = !(ACCEPT_UNICAST_ANY || w_bcastNext || w_localNext);
        6'd12:        w_byteBad = (s_axis_tdata != 8'h08);
        6'd13:        w_byteBad = (s_axis_tdata != 8'h06);
        6'd14:        w_byteBad = (s_axis_tdata != 8'h00);
        6'd15:        w_byteBad = (s_axis_tdata != 8'h01);
        6'd16:        w_byteBad = (s_axis_tdata != 8'h08);
        6'd17:        w_byteBad = (s_axis_tdata != 8'h00);
        6'd18:        w_byteBad = (s_axis_tdata != 8'h06);
        6'd19:        w_byteBad = (s_axis_tdata != 8'h04);
        6'd20:        w_byteBad = (s_axis_tdata != 8'h00);
        6'd21:        w_byteBad = !((s_axis_tdata == 8'h01) || (s_axis_tdata == 8'h02));
        default:      w_byteBad = 1'b0;
      endcase
    end
  end

  assign w_badNext = r_bad || w_byteBad;

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= RECV;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state: leave RECV once the header is complete, return on tlast
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RECV: begin
        if (w_lastXfer) begin
          w_nextState = RECV;
        end else if (w_xfer && (r_byteIdx == IDX_TPA_LAST)) begin
          w_nextState = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (w_lastXfer) begin
          w_nextState = RECV;
        end
      end
      default: w_nextState = RECV;
    endcase
  end

  // FSM outputs: the deliver/drop decision made on the tlast beat
  always_comb begin
    w_runt     = w_inRecv && (r_byteIdx < IDX_TPA_LAST);
    w_slotFree = !r_arpValid || m_arp_ready;
    w_deliver  = 1'b0;
    w_drop     = 1'b0;
    if (w_lastXfer) begin
      w_deliver = !w_runt && !w_badNext && !s_axis_tuser && w_slotFree;
      w_drop    = !w_deliver;
    end
  end

  // Stream acceptance goes high the cycle after reset and stays high
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= 1'b1;
    end
  end

  // Byte index and per-frame flags, restarted at every frame boundary
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_byteIdx  <= 6'd0;
      r_bad      <= 1'b0;
      r_dstBcast <= 1'b1;
      r_dstLocal <= 1'b1;
    end else if (w_lastXfer) begin
      r_byteIdx  <= 6'd0;
      r_bad      <= 1'b0;
      r_dstBcast <= 1'b1;
      r_dstLocal <= 1'b1;
    end else if (w_xfer) begin
      if (r_byteIdx != IDX_MAX) begin
        r_byteIdx <= r_byteIdx + 6'd1;
      end
      r_bad <= w_badNext;
      if (w_inRecv && (r_byteIdx <= IDX_DST_LAST)) begin
        r_dstBcast <= w_bcastNext;
        r_dstLocal <= w_localNext;
      end
    end
  end

  // Shift the ARP fields into the shadow register as their bytes arrive
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_shOper <= 16'h0000;
      r_shSha  <= 48'h0;
      r_shSpa  <= 32'h0;
      r_shTha  <= 48'h0;
      r_shTpa  <= 32'h0;
    end else if (w_xfer && w_inRecv) begin
      if ((r_byteIdx >= 6'd20) && (r_byteIdx <= 6'd21)) begin
        r_shOper <= {r_shOper[7:0], s_axis_tdata};
      end
      if ((r_byteIdx >= 6'd22) && (r_byteIdx <= 6'd27)) begin
        r_shSha <= {r_shSha[39:0], s_axis_tdata};
      end
      if ((r_byteIdx >= 6'd28) && (r_byteIdx <= 6'd31)) begin
        r_shSpa <= {r_shSpa[23:0], s_axis_tdata};
      end
      if ((r_byteIdx >= 6'd32) && (r_byteIdx <= 6'd37)) begin
        r_shTha <= {r_shTha[39:0], s_axis_tdata};
      end
      r_shTpa <= w_tpaNext;
    end
  end

  // Output record: load on deliver, otherwise hold until the consumer takes it
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_arpValid    <= 1'b0;
      r_arpOper     <= 16'h0000;
      r_arpSha      <= 48'h0;
      r_arpSpa      <= 32'h0;
      r_arpTha      <= 48'h0;
      r_arpTpa      <= 32'h0;
      r_arpTpaMatch <= 1'b0;
    end else if (w_deliver) begin
      r_arpValid    <= 1'b1;
      r_arpOper     <= r_shOper;
      r_arpSha      <= r_shSha;
      r_arpSpa      <= r_shSpa;
      r_arpTha      <= r_shTha;
      r_arpTpa      <= w_tpaNext;
      r_arpTpaMatch <= (w_tpaNext == local_ip);
    end else if (r_arpValid && m_arp_ready) begin
      r_arpValid <= 1'b0;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_statFrames <= '0;
      r_statArpOk  <= '0;
      r_statDrop   <= '0;
    end else begin
      if (w_lastXfer && (r_statFrames != CNT_MAX)) begin
        r_statFrames <= r_statFrames + CNT_ONE;
      end
      if (w_deliver && (r_statArpOk != CNT_MAX)) begin
        r_statArpOk <= r_statArpOk + CNT_ONE;
      end
      if (w_drop && (r_statDrop != CNT_MAX)) begin
        r_statDrop <= r_statDrop + CNT_ONE;
      end
    end
  end

  assign s_axis_tready   = r_tready;
  assign m_arp_valid     = r_arpValid;
  assign m_arp_oper      = r_arpOper;
  assign m_arp_sha       = r_arpSha;
  assign m_arp_spa       = r_arpSpa;
  assign m_arp_tha       = r_arpTha;
  assign m_arp_tpa       = r_arpTpa;
  assign m_arp_tpa_match = r_arpTpaMatch;
  assign stat_frames     = r_statFrames;
  assign stat_arp_ok     = r_statArpOk;
  assign stat_drop       = r_statDrop;

endmodule

// File: tb/tb_arp_rx_parser.sv
// tb_arp_rx_parser
// Directed bench for the ARP receive parser: frames are built byte by byte
// from header fields and the expected records and counters are hand-derived.
module tb_arp_rx_parser;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] LOCAL_IP  = 32'h0A_00_00_01;
  localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        m_arp_valid;
  logic        m_arp_ready;
  logic [15:0] m_arp_oper;
  logic [47:0] m_arp_sha;
  logic [31:0] m_arp_spa;
  logic [47:0] m_arp_tha;
  logic [31:0] m_arp_tpa;
  logic        m_arp_tpa_match;
  logic [15:0] stat_frames;
  logic [15:0] stat_arp_ok;
  logic [15:0] stat_drop;

  int checks;
  int errors;

  logic [7:0] frame [0:63];

  logic [15:0] capOper [0:31];
  logic [47:0] capSha  [0:31];
  logic [31:0] capSpa  [0:31];
  logic [47:0] capTha  [0:31];
  logic [31:0] capTpa  [0:31];
  int          capCount;

  arp_rx_parser #(.CNT_WIDTH(16), .ACCEPT_UNICAST_ANY(1'b0)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .local_mac       (LOCAL_MAC),
    .local_ip        (LOCAL_IP),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .m_arp_valid     (m_arp_valid),
    .m_arp_ready     (m_arp_ready),
    .m_arp_oper      (m_arp_oper),
    .m_arp_sha       (m_arp_sha),
    .m_arp_spa       (m_arp_spa),
    .m_arp_tha       (m_arp_tha),
    .m_arp_tpa       (m_arp_tpa),
    .m_arp_tpa_match (m_arp_tpa_match),
    .stat_frames     (stat_frames),
    .stat_arp_ok     (stat_arp_ok),
    .stat_drop       (stat_drop)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Record every handshake on the output so ordered delivery can be checked
  initial capCount = 0;
  always @(negedge aclk) begin
    if (aresetn && m_arp_valid && m_arp_ready && capCount < 32) begin
      capOper[capCount] <= m_arp_oper;
      capSha[capCount]  <= m_arp_sha;
      capSpa[capCount]  <= m_arp_spa;
      capTha[capCount]  <= m_arp_tha;
      capTpa[capCount]  <= m_arp_tpa;
      capCount          <= capCount + 1;
    end
  end

  // Fill the frame buffer with an Ethernet/ARP frame built from its fields
  task automatic buildFrame(input logic [47:0] dst, input logic [15:0] etype,
                            input logic [7:0] plen, input logic [15:0] oper,
                            input logic [47:0] sha, input logic [31:0] spa,
                            input logic [47:0] tha, input logic [31:0] tpa);
    logic [47:0] src;
    src = 48'h02_00_00_00_00_AA;
    for (int i = 0; i < 64; i++) frame[i] = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      frame[i]      = dst[47-8*i -: 8];
      frame[6+i]    = src[47-8*i -: 8];
      frame[22+i]   = sha[47-8*i -: 8];
      frame[32+i]   = tha[47-8*i -: 8];
    end
    frame[12] = etype[15:8];
    frame[13] = etype[7:0];
    frame[14] = 8'h00;
    frame[15] = 8'h01;
    frame[16] = 8'h08;
    frame[17] = 8'h00;
    frame[18] = 8'h06;
    frame[19] = plen;
    frame[20] = oper[15:8];
    frame[21] = oper[7:0];
    for (int i = 0; i < 4; i++) begin
      frame[28+i] = spa[31-8*i -: 8];
      frame[38+i] = tpa[31-8*i -: 8];
    end
  endtask

  // Drive len bytes of the frame buffer, optionally with a gap before odd bytes
  task automatic sendFrame(input int len, input bit tuserVal, input bit gaps,
                           input bit withLast);
    for (int i = 0; i < len; i++) begin
      if (gaps && (i % 2 == 1)) begin
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
      end
      @(negedge aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frame[i];
      s_axis_tlast  = withLast && (i == len - 1);
      s_axis_tuser  = tuserVal && (i == len - 1);
    end
  endtask

  task automatic idleStream();
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge aclk);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("[TB] FAIL rst_tready: got %0b expected 0", s_axis_tready); end
    checks++; if (m_arp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0b expected 0", m_arp_valid); end
    checks++; if (stat_frames !== 16'd0 || stat_arp_ok !== 16'd0 || stat_drop !== 16'd0) begin errors++; $display("[TB] FAIL rst_stats: got %0d/%0d/%0d expected 0/0/0", stat_frames, stat_arp_ok, stat_drop); end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("[TB] FAIL rst_tready_up: got %0b expected 1", s_axis_tready); end
  endtask

  task automatic test_broadcast_request();
    applyReset();
    m_arp_ready = 1'b1;
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd1, 48'h00_11_22_33_44_55, 32'h0A000002, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bc_valid: got %0b expected 1", m_arp_valid); end
    checks++; if (m_arp_oper !== 16'd1) begin errors++; $display("[TB] FAIL bc_oper: got %0h expected 1", m_arp_oper); end
    checks++; if (m_arp_sha !== 48'h00_11_22_33_44_55) begin errors++; $display("[TB] FAIL bc_sha: got %h expected 001122334455", m_arp_sha); end
    checks++; if (m_arp_spa !== 32'h0A000002) begin errors++; $display("[TB] FAIL bc_spa: got %h expected 0a000002", m_arp_spa); end
    checks++; if (m_arp_tpa !== LOCAL_IP) begin errors++; $display("[TB] FAIL bc_tpa: got %h expected %h", m_arp_tpa, LOCAL_IP); end
    checks++; if (m_arp_tpa_match !== 1'b1) begin errors++; $display("[TB] FAIL bc_tpa_match: got %0b expected 1", m_arp_tpa_match); end
    checks++; if (stat_arp_ok !== 16'd1 || stat_drop !== 16'd0 || stat_frames !== 16'd1) begin errors++; $display("[TB] FAIL bc_stats: got ok=%0d drop=%0d frames=%0d expected 1/0/1", stat_arp_ok, stat_drop, stat_frames); end
    @(negedge aclk);
    checks++; if (m_arp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bc_valid_clear: got %0b expected 0", m_arp_valid); end
  endtask

  task automatic test_runt();
    applyReset();
    m_arp_ready = 1'b1;
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd1, 48'h00_11_22_33_44_55, 32'h0A000002, 48'h0, LOCAL_IP);
    sendFrame(31, 1'b0, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b0) begin errors++; $display("[TB] FAIL runt_valid: got %0b expected 0", m_arp_valid); end
    checks++; if (stat_drop !== 16'd1 || stat_frames !== 16'd1 || stat_arp_ok !== 16'd0) begin errors++; $display("[TB] FAIL runt_stats: got drop=%0d frames=%0d ok=%0d expected 1/1/0", stat_drop, stat_frames, stat_arp_ok); end
    buildFrame(LOCAL_MAC, 16'h0806, 8'h04, 16'd2, 48'h0C_0D_0E_0F_10_11, 32'hC0A80105, LOCAL_MAC, 32'h0A000063);
    sendFrame(42, 1'b0, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b1) begin errors++; $display("[TB] FAIL runt_next_valid: got %0b expected 1", m_arp_valid); end
    checks++; if (m_arp_oper !== 16'd2) begin errors++; $display("[TB] FAIL runt_next_oper: got %0h expected 2", m_arp_oper); end
    checks++; if (m_arp_tha !== LOCAL_MAC) begin errors++; $display("[TB] FAIL runt_next_tha: got %h expected %h", m_arp_tha, LOCAL_MAC); end
    checks++; if (m_arp_tpa_match !== 1'b0) begin errors++; $display("[TB] FAIL runt_next_tpa_match: got %0b expected 0", m_arp_tpa_match); end
    checks++; if (stat_arp_ok !== 16'd1 || stat_frames !== 16'd2) begin errors++; $display("[TB] FAIL runt_next_stats: got ok=%0d frames=%0d expected 1/2", stat_arp_ok, stat_frames); end
  endtask

  task automatic test_header_errors();
    applyReset();
    m_arp_ready = 1'b1;
    buildFrame(BCAST, 16'h0800, 8'h04, 16'd1, 48'h00_11_22_33_44_55, 32'h0A000002, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b0) begin errors++; $display("[TB] FAIL etype_valid: got %0b expected 0", m_arp_valid); end
    buildFrame(BCAST, 16'h0806, 8'h06, 16'd1, 48'h00_11_22_33_44_55, 32'h0A000002, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b0) begin errors++; $display("[TB] FAIL plen_valid: got %0b expected 0", m_arp_valid); end
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd1, 48'h00_11_22_33_44_55, 32'h0A000002, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b1, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b0) begin errors++; $display("[TB] FAIL tuser_valid: got %0b expected 0", m_arp_valid); end
    checks++; if (stat_drop !== 16'd3 || stat_frames !== 16'd3 || stat_arp_ok !== 16'd0) begin errors++; $display("[TB] FAIL hdr_stats: got drop=%0d frames=%0d ok=%0d expected 3/3/0", stat_drop, stat_frames, stat_arp_ok); end
    buildFrame(48'h02_00_00_00_00_99, 16'h0806, 8'h04, 16'd1, 48'h00_11_22_33_44_55, 32'h0A000002, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    idleStream();
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd3, 48'h00_11_22_33_44_55, 32'h0A000002, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b0 || stat_drop !== 16'd5 || stat_arp_ok !== 16'd0) begin errors++; $display("[TB] FAIL dst_oper_drop: got valid=%0b drop=%0d ok=%0d expected 0/5/0", m_arp_valid, stat_drop, stat_arp_ok); end
  endtask

  task automatic test_backpressure();
    applyReset();
    m_arp_ready = 1'b0;
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd1, 48'hAA_00_00_00_00_01, 32'h0A000005, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b1 || m_arp_sha !== 48'hAA_00_00_00_00_01) begin errors++; $display("[TB] FAIL bp_first: got valid=%0b sha=%h expected 1/aa0000000001", m_arp_valid, m_arp_sha); end
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd2, 48'hBB_00_00_00_00_02, 32'h0A000006, 48'h0, 32'h0A000007);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    idleStream();
    repeat (3) @(negedge aclk);
    checks++; if (m_arp_valid !== 1'b1 || m_arp_sha !== 48'hAA_00_00_00_00_01 || m_arp_spa !== 32'h0A000005 || m_arp_oper !== 16'd1 || m_arp_tpa_match !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable: got valid=%0b sha=%h spa=%h oper=%0h match=%0b expected 1/aa0000000001/0a000005/1/1", m_arp_valid, m_arp_sha, m_arp_spa, m_arp_oper, m_arp_tpa_match); end
    checks++; if (stat_drop !== 16'd1 || stat_arp_ok !== 16'd1 || stat_frames !== 16'd2) begin errors++; $display("[TB] FAIL bp_stats: got drop=%0d ok=%0d frames=%0d expected 1/1/2", stat_drop, stat_arp_ok, stat_frames); end
    #1 m_arp_ready = 1'b1;
    @(negedge aclk);
    checks++; if (m_arp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got %0b expected 0", m_arp_valid); end
  endtask

  task automatic test_back_to_back();
    int base;
    applyReset();
    m_arp_ready = 1'b1;
    base = capCount;
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd1, 48'hA0_A1_A2_A3_A4_A5, 32'h0A000010, 48'h0, LOCAL_IP);
    sendFrame(42, 1'b0, 1'b1, 1'b1);
    buildFrame(LOCAL_MAC, 16'h0806, 8'h04, 16'd2, 48'hB0_B1_B2_B3_B4_B5, 32'h0A000011, LOCAL_MAC, 32'h0A000020);
    sendFrame(42, 1'b0, 1'b1, 1'b1);
    idleStream();
    repeat (2) @(negedge aclk);
    checks++; if (capCount - base !== 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", capCount - base); end
    if (capCount - base >= 2) begin
      checks++; if (capOper[base] !== 16'd1 || capSha[base] !== 48'hA0_A1_A2_A3_A4_A5 || capSpa[base] !== 32'h0A000010 || capTha[base] !== 48'h0 || capTpa[base] !== LOCAL_IP) begin errors++; $display("[TB] FAIL b2b_rec0: got oper=%0h sha=%h spa=%h tha=%h tpa=%h", capOper[base], capSha[base], capSpa[base], capTha[base], capTpa[base]); end
      checks++; if (capOper[base+1] !== 16'd2 || capSha[base+1] !== 48'hB0_B1_B2_B3_B4_B5 || capSpa[base+1] !== 32'h0A000011 || capTha[base+1] !== LOCAL_MAC || capTpa[base+1] !== 32'h0A000020) begin errors++; $display("[TB] FAIL b2b_rec1: got oper=%0h sha=%h spa=%h tha=%h tpa=%h", capOper[base+1], capSha[base+1], capSpa[base+1], capTha[base+1], capTpa[base+1]); end
    end
    checks++; if (stat_arp_ok !== 16'd2 || stat_drop !== 16'd0) begin errors++; $display("[TB] FAIL b2b_stats: got ok=%0d drop=%0d expected 2/0", stat_arp_ok, stat_drop); end
  endtask

  task automatic test_reset_midframe();
    applyReset();
    m_arp_ready = 1'b0;
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd1, 48'h11_11_11_11_11_11, 32'h0A000030, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    sendFrame(20, 1'b0, 1'b0, 1'b0);
    @(negedge aclk);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    checks++; if (m_arp_valid !== 1'b0 || m_arp_oper !== 16'd0 || m_arp_sha !== 48'h0 || m_arp_tpa_match !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_out: got valid=%0b oper=%0h sha=%h match=%0b expected all 0", m_arp_valid, m_arp_oper, m_arp_sha, m_arp_tpa_match); end
    checks++; if (stat_frames !== 16'd0 || stat_arp_ok !== 16'd0 || stat_drop !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_stats: got %0d/%0d/%0d expected 0/0/0", stat_frames, stat_arp_ok, stat_drop); end
    aresetn = 1'b1;
    @(negedge aclk);
    m_arp_ready = 1'b1;
    buildFrame(BCAST, 16'h0806, 8'h04, 16'd2, 48'h22_22_22_22_22_22, 32'h0A000031, 48'h0, LOCAL_IP);
    sendFrame(60, 1'b0, 1'b0, 1'b1);
    idleStream();
    checks++; if (m_arp_valid !== 1'b1 || m_arp_sha !== 48'h22_22_22_22_22_22 || m_arp_oper !== 16'd2) begin errors++; $display("[TB] FAIL mid_rst_next: got valid=%0b sha=%h oper=%0h expected 1/222222222222/2", m_arp_valid, m_arp_sha, m_arp_oper); end
    checks++; if (stat_frames !== 16'd1 || stat_arp_ok !== 16'd1 || stat_drop !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_next_stats: got %0d/%0d/%0d expected 1/1/0", stat_frames, stat_arp_ok, stat_drop); end
  endtask

  // Run each scenario in turn and report the totals
  initial begin
    checks        = 0;
    errors        = 0;
    aresetn       = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_arp_ready   = 1'b0;
    test_reset();
    test_broadcast_request();
    test_runt();
    test_header_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
- Receive-side front end of the ARP core: consumes raw Ethernet frames from an 8-bit AXI-Stream and validates Ethernet/ARP headers.
- Extracts the ARP fields and presents one parsed-packet record per good frame to the ARP core over a valid/ready handshake.
- Never back-pressures the MAC; frames that cannot be delivered are dropped and counted.

Parameters:
- CNT_WIDTH, 16, width of the saturating statistics counters.
- ACCEPT_UNICAST_ANY, 0, 1 = skip the destination-MAC filter (promiscuous).

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- local_mac  in  48  station MAC; static, sampled every cycle
- local_ip  in  32  station IPv4; static
- s_axis_tdata  in  8  frame byte, first byte = dst MAC[47:40]
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accept
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  frame error; meaningful on the tlast beat only
- m_arp_valid  out  1  parsed record valid
- m_arp_ready  in  1  ARP core accepts record
- m_arp_oper  out  16  1 = request, 2 = reply
- m_arp_sha  out  48  sender hardware address
- m_arp_spa  out  32  sender protocol address
- m_arp_tha  out  48  target hardware address
- m_arp_tpa  out  32  target protocol address
- m_arp_tpa_match  out  1  tpa == local_ip
- stat_frames  out  CNT_WIDTH  frames seen (any tlast beat)
- stat_arp_ok  out  CNT_WIDTH  records delivered to the output register
- stat_drop  out  CNT_WIDTH  frames dropped for any reason

Behaviour:
- Reset (aresetn = 0 at a rising edge): all outputs 0, s_axis_tready = 0, state = RECV, byte index = 0. The cycle after reset deasserts, s_axis_tready = 1; it then stays 1 permanently.
- A beat is a transfer when tvalid && tready. The byte index counts 0..42 and saturates at 42.
- Byte map (big-endian):
  - 0-5 dst MAC; 6-11 src MAC (ignored); 12-13 ethertype, must be 0x0806.
  - 14-15 HTYPE 0x0001; 16-17 PTYPE 0x0800; 18 HLEN 0x06; 19 PLEN 0x04.
  - 20-21 OPER, must be 1 or 2.
  - 22-27 SHA; 28-31 SPA; 32-37 THA; 38-41 TPA.
  - 42 and above: padding/FCS, ignored.
- Dst MAC filter: pass if dst == FF:FF:FF:FF:FF:FF, or dst == local_mac, or ACCEPT_UNICAST_ANY = 1.
- Any field mismatch latches an internal bad flag; bytes are still consumed until tlast.
- States:
  - RECV: shift fields into a shadow register and check each byte as it arrives.
    - tlast with index < 41 (runt): drop.
    - tlast at index >= 41: go to decide.
    - Index reaches 42 without tlast: go to WAIT_LAST.
  - WAIT_LAST: consume bytes until tlast, then decide.
  - Decide (same cycle as the tlast beat; no separate state): deliver if not bad, not runt, tuser = 0, and the output slot is free. Otherwise count a drop. In either case return to RECV with index 0 and the bad flag cleared.
- Output slot is free when m_arp_valid = 0, or when m_arp_valid && m_arp_ready in the same cycle.
- On deliver: shadow fields are copied to the m_arp_* registers, m_arp_valid = 1 in the cycle after the tlast beat, and m_arp_tpa_match is computed from the shadow TPA at copy time.
- m_arp_valid holds, with all fields stable, until m_arp_valid && m_arp_ready; it then clears the next cycle unless a new delivery coincides, in which case it stays 1 with the new data.
- The shadow register is separate from the output register, so a new frame parses while a record is pending. It is dropped only if its decide point finds the slot still occupied.
- Counters:
  - stat_frames increments on every tlast transfer.
  - stat_arp_ok increments on every deliver.
  - stat_drop increments on every non-deliver decide.
  - All counters saturate at all-ones and never wrap.
  - stat_frames = stat_arp_ok + stat_drop until saturation.
- tvalid gaps are permitted anywhere; the index advances only on transfers.
- Reset mid-frame discards the partial frame and pending record; the parser restarts expecting byte 0.

Test Plan:
- Broadcast request, 60-byte frame: ethertype 0806, OPER 1, SPA 10.0.0.2, TPA = local_ip 10.0.0.1 -> m_arp_valid one cycle after tlast; oper = 1, tpa_match = 1; stat_arp_ok = 1, stat_drop = 0.
- Runt, tlast at byte 30 -> no m_arp_valid; stat_drop = 1, stat_frames = 1. The next good frame parses correctly.
- Ethertype 0x0800 frame; a separate frame with PLEN = 6; a separate frame with tuser = 1 on tlast -> each dropped; stat_drop = 3, no output.
- m_arp_ready held 0 while two good frames arrive -> first record stays stable; second is dropped, stat_drop = 1. Releasing ready clears valid the next cycle.
- Back-to-back 42-byte frames with m_arp_ready = 1 and a one-cycle tvalid gap every other byte -> both delivered in order with correct SHA/SPA/THA/TPA.
- Assert aresetn = 0 at byte 20 of a good frame -> outputs and counters 0. A following complete frame is delivered normally.
